// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, PC step and
// the default reset address.
package fetch_pkg;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  localparam int unsigned PC_INC = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Pointer width for a circular buffer of n entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue holding {pc, instr} pairs between fetch and decode.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push, push_pc/instr   write an entry at the tail
//   pop                   remove the head entry (ignored when empty)
//   flush                 empty the queue; overrides push and pop
//   full, empty, count    occupancy status
//   head_pc, head_instr   contents of the head entry
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_pc,
  input  logic [WIDTH-1:0]             push_instr,
  input  logic                         pop,
  input  logic                         flush,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head_pc,
  output logic [WIDTH-1:0]             head_instr
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign {head_pc, head_instr} = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents only matter once counted as occupied.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) begin
      mem[wr_ptr] <= {push_pc, push_instr};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches, queues returned
// instructions for decode and handles branch redirects by flushing the queue
// and draining in-flight responses.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   imem_req_valid/ready, imem_addr    fetch request channel
//   imem_resp_valid, imem_rdata        in-order fetch responses
//   branch_valid, branch_target        redirect from decode/execute
//   dec_valid/ready, dec_instr, dec_pc head of the instruction queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_resp_valid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_target,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [WIDTH-1:0] dec_instr,
  output logic [WIDTH-1:0] dec_pc
);

  localparam int unsigned      CW         = $clog2(DEPTH + 1);
  localparam int unsigned      SW         = CW + 1;
  localparam int unsigned      PW         = ptr_width(DEPTH);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_t           state, state_next;
  logic [WIDTH-1:0] pc, pc_next;
  logic [CW-1:0]    outstanding, outstanding_next;
  logic [WIDTH-1:0] addr_rec [DEPTH];
  logic [PW-1:0]    rec_wr, rec_rd;

  logic             in_run, accept, resp_fire;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] head_pc, head_instr;

  assign in_run = rst_n && (state == S_RUN);

  // Issue only when every in-flight response is guaranteed a queue slot.
  assign imem_req_valid = in_run && !branch_valid && !fifo_full &&
                          (({1'b0, outstanding} + {1'b0, fifo_count}) < SW'(DEPTH));
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  // Responses with nothing in flight are stale (e.g. from before a reset).
  assign resp_fire      = rst_n && imem_resp_valid && (outstanding != '0);

  assign fifo_flush = in_run && branch_valid;
  assign fifo_push  = in_run && !branch_valid && resp_fire;
  assign fifo_pop   = in_run && !branch_valid && dec_valid && dec_ready;

  assign dec_valid  = rst_n && !fifo_empty;
  assign dec_instr  = dec_valid ? head_instr : '0;
  assign dec_pc     = dec_valid ? head_pc    : '0;

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_pc    (addr_rec[rec_rd]),
    .push_instr (imem_rdata),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  // Next-state, PC and outstanding-count logic.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    outstanding_next = outstanding;

    case ({accept, resp_fire})
      2'b10:   outstanding_next = outstanding + CW'(1);
      2'b01:   outstanding_next = outstanding - CW'(1);
      default: outstanding_next = outstanding;
    endcase

    if (branch_valid) begin
      pc_next = branch_target & ALIGN_MASK;
    end else if (accept) begin
      pc_next = pc + WIDTH'(PC_INC);
    end

    case (state)
      S_RUN: begin
        if (branch_valid && (outstanding_next != '0)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A fresh redirect keeps draining; otherwise leave once empty.
        if (!branch_valid && (outstanding_next == '0)) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_RUN;
    endcase
  end

  // State register and address-record pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RUN;
      pc          <= RESET_PC & ALIGN_MASK;
      outstanding <= '0;
      rec_wr      <= '0;
      rec_rd      <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      outstanding <= outstanding_next;
      if (accept) begin
        rec_wr <= (rec_wr == PW'(DEPTH - 1)) ? '0 : rec_wr + PW'(1);
      end
      if (resp_fire) begin
        rec_rd <= (rec_rd == PW'(DEPTH - 1)) ? '0 : rec_rd + PW'(1);
      end
    end
  end

  // Address of each accepted request, consumed in order by its response.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_rec[rec_wr] <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model, an
// in-order memory with random latency, directed scenarios and random traffic.
module tb_fetch_unit;

  localparam int unsigned D   = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  fetch_unit #(.WIDTH(32), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_rdata      (imem_rdata),
    .branch_valid    (branch_valid),
    .branch_target   (branch_target),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Memory environment
  typedef struct { logic [31:0] addr; int rdy; } mreq_t;
  mreq_t mem_q[$];
  bit    resp_en = 1'b1;
  bit    stray   = 1'b0;
  int    lat_max = 0;
  bit    real_resp;
  bit    dut_acc;
  logic [31:0] acc_addr;

  // Reference model: pc, drain flag, in-flight addresses, decode queue
  logic [31:0] m_pc = RPC;
  bit          m_drain = 1'b0;
  bit          m_rv;
  logic [31:0] m_inf[$];
  logic [63:0] m_dq[$];

  // Observations of the DUT
  logic [63:0] pops[$];
  logic [31:0] reqs[$];
  bit          s_rv, s_dv;
  logic [31:0] s_addr, s_dpc;

  int pr_ready, pr_dec, pr_resp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    bit exp_dv;
    m_rv   = rst_n && !m_drain && !branch_valid && ((m_inf.size() + m_dq.size()) < D);
    exp_dv = rst_n && (m_dq.size() > 0);
    check("imem_req_valid", 64'(imem_req_valid), 64'(m_rv));
    if (m_rv || !rst_n) check("imem_addr", 64'(imem_addr), 64'(m_pc));
    check("dec_valid", 64'(dec_valid), 64'(exp_dv));
    if (exp_dv) begin
      check("dec_pc", 64'(dec_pc), 64'(m_dq[0][63:32]));
      check("dec_instr", 64'(dec_instr), 64'(m_dq[0][31:0]));
    end else if (!rst_n) begin
      check("dec_pc_reset", 64'(dec_pc), 64'h0);
      check("dec_instr_reset", 64'(dec_instr), 64'h0);
    end
  endtask

  task automatic model_update();
    bit          resp, acc;
    logic [31:0] a;
    a = '0;
    if (!rst_n) begin
      m_pc = RPC; m_drain = 1'b0; m_inf.delete(); m_dq.delete();
      return;
    end
    acc  = m_rv && imem_req_ready;
    resp = imem_resp_valid && (m_inf.size() > 0);
    if (resp) begin a = m_inf[0]; m_inf.delete(0); end
    if (!m_drain) begin
      if (branch_valid) begin
        m_dq.delete();
        m_pc    = branch_target & ~32'h3;
        m_drain = (m_inf.size() > 0);
      end else begin
        if (dec_ready && m_dq.size() > 0) m_dq.delete(0);
        if (resp) m_dq.push_back({a, mem_word(a)});
        if (acc) begin m_inf.push_back(m_pc); m_pc = m_pc + 32'd4; end
      end
    end else begin
      if (branch_valid) m_pc = branch_target & ~32'h3;
      else m_drain = (m_inf.size() > 0);
    end
  endtask

  // One clock cycle; inputs are set by the caller just after a rising edge.
  task automatic tick();
    real_resp = 1'b0;
    if (stray) begin
      imem_resp_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    end else if (rst_n && resp_en && mem_q.size() > 0 && mem_q[0].rdy <= cyc) begin
      imem_resp_valid = 1'b1; imem_rdata = mem_word(mem_q[0].addr); real_resp = 1'b1;
    end else begin
      imem_resp_valid = 1'b0; imem_rdata = $urandom;
    end
    #4;
    compare();
    s_rv = imem_req_valid; s_addr = imem_addr; s_dv = dec_valid; s_dpc = dec_pc;
    dut_acc  = imem_req_valid && imem_req_ready;
    acc_addr = imem_addr;
    if (dut_acc) reqs.push_back(imem_addr);
    if (dec_valid && dec_ready) pops.push_back({dec_pc, dec_instr});
    @(posedge clk);
    model_update();
    if (!rst_n) mem_q.delete();
    else begin
      if (real_resp) mem_q.delete(0);
      if (dut_acc) mem_q.push_back('{acc_addr, cyc + 1 + int'($urandom_range(0, lat_max))});
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    pops.delete(); reqs.delete();
  endtask

  task automatic run_until_pops(input int n, input int budget, input string name);
    int k = 0;
    while (pops.size() < n && k < budget) begin tick(); k++; end
    check({name, "_progress"}, 64'(pops.size() >= n), 64'h1);
    while (pops.size() < n) pops.push_back('1);
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset values
    tick();
    check("rst_req_valid", 64'(s_rv), 64'h0);
    check("rst_addr", 64'(s_addr), 64'(RPC));
    check("rst_dec_valid", 64'(s_dv), 64'h0);

    // Straight-line fetch with a 1-cycle memory
    rst_n = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b1; lat_max = 0; resp_en = 1'b1;
    pops.delete(); reqs.delete();
    tick();
    check("first_req_valid", 64'(s_rv), 64'h1);
    check("first_req_addr", 64'(s_addr), 64'(RPC));
    run_until_pops(3, 20, "seq");
    check("seq0", pops[0], {32'h0, 32'h1357_6420});
    check("seq1", pops[1], {32'h4, 32'h1353_6424});
    check("seq2", pops[2], {32'h8, 32'h135F_6428});

    // Decode back-pressure: credit stops issue after two entries
    do_reset();
    dec_ready = 1'b0;
    repeat (8) tick();
    check("stall_req_count", 64'(reqs.size()), 64'd2);
    check("stall_req_valid", 64'(s_rv), 64'h0);
    check("stall_dec_valid", 64'(s_dv), 64'h1);
    check("stall_dec_pc", 64'(s_dpc), 64'h0);
    dec_ready = 1'b1;
    run_until_pops(3, 20, "resume");
    check("resume1", 64'(pops[1][63:32]), 64'h4);
    check("resume2", 64'(pops[2][63:32]), 64'h8);

    // Memory back-pressure holds the address
    do_reset();
    begin
      int k = 0;
      while (imem_addr != 32'h8 && k < 20) begin tick(); k++; end
      check("reach_addr8", 64'(imem_addr), 64'h8);
    end
    imem_req_ready = 1'b0;
    repeat (3) begin tick(); check("held_addr", 64'(s_addr), 64'h8); end
    imem_req_ready = 1'b1;
    run_until_pops(6, 40, "backpressure");
    while (reqs.size() < 6) reqs.push_back('1);
    for (int i = 0; i < 6; i++) check("req_order", 64'(reqs[i]), 64'(32'(4 * i)));

    // Redirect with two responses outstanding
    do_reset();
    resp_en = 1'b0;
    tick(); tick();
    check("two_outstanding", 64'(reqs.size()), 64'd2);
    branch_valid = 1'b1; branch_target = 32'h103;
    tick();
    check("branch_cycle_valid", 64'(s_rv), 64'h0);
    branch_valid = 1'b0; resp_en = 1'b1; reqs.delete(); pops.delete();
    tick();
    check("drain_no_req", 64'(s_rv), 64'h0);
    run_until_pops(1, 20, "redirect");
    check("redirect_pop", pops[0], {32'h100, 32'h1257_6520});
    check("redirect_req", 64'(reqs[0]), 64'h100);

    // Address wrap at the top of the space
    branch_valid = 1'b1; branch_target = 32'hFFFF_FFF8;
    tick();
    branch_valid = 1'b0; reqs.delete();
    begin
      int k = 0;
      while (reqs.size() < 3 && k < 30) begin tick(); k++; end
      check("wrap_progress", 64'(reqs.size() >= 3), 64'h1);
      while (reqs.size() < 3) reqs.push_back('1);
    end
    check("wrap0", 64'(reqs[0]), 64'hFFFF_FFF8);
    check("wrap1", 64'(reqs[1]), 64'hFFFF_FFFC);
    check("wrap2", 64'(reqs[2]), 64'h0);

    // Reset while draining; a late response must be ignored
    do_reset();
    resp_en = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    tick();
    branch_valid = 1'b1; branch_target = 32'h40;
    tick();
    branch_valid = 1'b0;
    tick();
    check("drain_hold", 64'(s_rv), 64'h0);
    rst_n = 1'b0; stray = 1'b1;
    tick();
    rst_n = 1'b1; resp_en = 1'b1; imem_req_ready = 1'b1; pops.delete();
    tick();
    stray = 1'b0;
    check("post_rst_valid", 64'(s_rv), 64'h1);
    check("post_rst_addr", 64'(s_addr), 64'(RPC));
    check("post_rst_dec_valid", 64'(s_dv), 64'h0);
    run_until_pops(1, 20, "post_rst");
    check("post_rst_pop", pops[0], {32'h0, 32'h1357_6420});

    // Random traffic
    for (int blk = 0; blk < 15; blk++) begin
      lat_max  = int'($urandom_range(0, 3));
      pr_ready = int'($urandom_range(30, 100));
      pr_dec   = int'($urandom_range(20, 100));
      pr_resp  = int'($urandom_range(30, 100));
      repeat (200) begin
        rst_n          = ($urandom_range(0, 499) != 0);
        imem_req_ready = (int'($urandom_range(0, 99)) < pr_ready);
        dec_ready      = (int'($urandom_range(0, 99)) < pr_dec);
        resp_en        = (int'($urandom_range(0, 99)) < pr_resp);
        branch_valid   = ($urandom_range(0, 99) < 4);
        branch_target  = $urandom;
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32, instruction and address width in bits.
REQ-002 Parameter DEPTH, default 2, number of instruction queue entries and the maximum number of outstanding memory requests.
REQ-003 Parameter RESET_PC, default 0, fetch address after reset.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-008 imem_addr  out  WIDTH  word address of the request; bits [1:0] always 0.
REQ-009 imem_resp_valid  in  1  returned instruction valid; responses are in order, at least 1 cycle after acceptance.
REQ-010 imem_rdata  in  WIDTH  returned instruction word.
REQ-011 branch_valid  in  1  redirect request from decode/execute.
REQ-012 branch_target  in  WIDTH  redirect address.
REQ-013 dec_valid  out  1  head queue entry valid toward decode.
REQ-014 dec_ready  in  1  decode consumes the head entry.
REQ-015 dec_instr  out  WIDTH  head instruction; decode slices [WIDTH-9:0] for immediate extension.
REQ-016 dec_pc  out  WIDTH  address of dec_instr.

Function
REQ-017 Request handshake: a request transfers when imem_req_valid and imem_req_ready are both 1; imem_addr is held stable while valid=1 and ready=0.
REQ-018 The unit asserts imem_req_valid in S_RUN only when (outstanding + queue occupancy) < DEPTH, so a response always has a free queue slot.
REQ-019 On each accepted request: PC <= PC + 4, wrapping modulo 2^WIDTH; outstanding <= outstanding + 1.
REQ-020 On each response: outstanding decrements; in S_RUN the pair {pc, imem_rdata} is pushed to the queue tail, with pc taken from a per-request address record.
REQ-021 Same-cycle accept and response: outstanding is unchanged.
REQ-022 Decode handshake: the head entry pops when dec_valid and dec_ready are both 1; dec_valid = queue not empty; dec_valid stays 1 with stable data until the pop.
REQ-023 Same-cycle push and pop on a full queue is legal; occupancy is unchanged.
REQ-024 States: S_RUN and S_DRAIN.
REQ-025 branch_valid in S_RUN: the queue is flushed; that cycle's pop and push are ignored; PC <= {branch_target[WIDTH-1:2], 2'b00}; imem_req_valid is 0 that cycle.
REQ-026 After a branch, the next state is S_DRAIN if in-flight requests remain (outstanding after this cycle's accept or response > 0); otherwise it is S_RUN.
REQ-027 S_DRAIN: no requests are issued; responses only decrement outstanding and are discarded; the unit returns to S_RUN in the cycle after outstanding reaches 0.
REQ-028 branch_valid in S_DRAIN: PC is reloaded with the new target; the unit stays in S_DRAIN.
REQ-029 First request after a redirect: its address is the redirected PC; latency from branch_valid to imem_req_valid is 1 cycle when nothing is in flight.

Reset
REQ-030 When rst_n = 0 at a clock edge, the following load: PC = RESET_PC, state = S_RUN, outstanding = 0, queue empty.
REQ-031 During reset, outputs are: imem_req_valid = 0, dec_valid = 0, dec_instr = 0, dec_pc = 0, imem_addr = RESET_PC.
REQ-032 Reset mid-operation discards all in-flight responses; the memory is reset together with this unit.
REQ-033 In the first cycle after rst_n deasserts, imem_req_valid = 1 and imem_addr = RESET_PC.

Structure
REQ-034 Package fetch_pkg: state enum {S_RUN, S_DRAIN}, PC_INC = 4, default RESET_PC.
REQ-035 Sub-module fetch_fifo: DEPTH-entry queue of {pc, instr} with push, pop, flush, full, empty and count ports; it is instantiated once.
REQ-036 The per-request address record is a DEPTH-entry circular buffer inside fetch_unit.

Verification
REQ-037 Reset, then ready=1, 1-cycle memory, dec_ready=1 -> dec_pc sequence 0x0, 0x4, 0x8; dec_instr matches memory at each address.
REQ-038 dec_ready=0 -> after exactly 2 entries, imem_req_valid=0; dec_pc=0x0 held stable; release dec_ready -> resumes 0x4 without loss.
REQ-039 branch_valid with target 0x103 and 2 responses outstanding -> both responses dropped, state S_DRAIN, next imem_addr = 0x100, next dec_pc = 0x100.
REQ-040 imem_req_ready=0 for 3 cycles -> imem_addr held at 0x8; no duplicate or skipped addresses afterwards.
REQ-041 PC = 0xFFFFFFFC accepted -> next imem_addr = 0x00000000.
REQ-042 rst_n=0 during S_DRAIN with 1 outstanding -> next cycle imem_addr = RESET_PC, dec_valid=0, late response ignored.
